// File: rtl/video_pattern_gen.sv
// Raster timing source: vsync/hsync/valid for any resolution, with a selectable
// test pattern in the active window, run/stop control and a completed-frame counter.
module video_pattern_gen #(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              pre_img_vsync,
  output logic              pre_img_hsync,
  output logic              pre_img_valid,
  output logic [DATA_W-1:0] pre_img_data,
  output logic [CNT_W-1:0]  img_x,
  output logic [CNT_W-1:0]  img_y,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_DISP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic [1:0]         mode_q, mode_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               vsync_q, vsync_d;
  logic               hsync_q, hsync_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               fs_q, fs_d;

  logic               running;
  logic               frameEnd;
  logic               inAct;

  assign running  = (state_q == RUN);
  assign frameEnd = running && (h_q == H_LAST) && (v_q == V_LAST);
  assign inAct    = running &&
                    (h_q >= H_ACT_S) && (h_q < H_ACT_E) &&
                    (v_q >= V_ACT_S) && (v_q < V_ACT_E);

  // Mode and the stop request only take effect on a frame boundary, so a frame is never cut short.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) begin
          state_d = RUN;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (frameEnd) begin
          h_d         = '0;
          v_d         = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (en) mode_d = mode;
          else    state_d = IDLE;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          v_d = v_q + CNT_W'(1);
        end else begin
          h_d = h_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vsync_d = running && (v_q < V_SYNC_C);
    hsync_d = running && (h_q < H_SYNC_C);
    valid_d = inAct;
    fs_d    = running && (h_q == '0) && (v_q == '0);
    x_d     = inAct ? (h_q - H_ACT_S) : '0;
    y_d     = inAct ? (v_q - V_ACT_S) : '0;
    data_d  = '0;
    if (inAct) begin
      case (mode_q)
        2'd0:    data_d = DATA_W'(x_d);
        2'd1:    data_d = DATA_W'(y_d);
        2'd2:    data_d = {DATA_W{x_d[5] ^ y_d[5]}};
        default: data_d = DATA_W'(frame_cnt_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
    end
  end

  assign pre_img_vsync = vsync_q;
  assign pre_img_hsync = hsync_q;
  assign pre_img_valid = valid_q;
  assign pre_img_data  = data_q;
  assign img_x         = x_q;
  assign img_y         = y_q;
  assign frame_start   = fs_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: a tiny 15x7 raster for timing/control
// checks and a 67x43 raster wide enough to exercise the checker pattern.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        vs, hs, vld, fs;
  logic [7:0]  data;
  logic [11:0] x, y;
  logic [15:0] fc;

  logic        rst2_n = 1'b0;
  logic        en2 = 1'b0;
  logic [1:0]  mode2 = 2'd0;
  logic        vs2, hs2, vld2, fs2;
  logic [7:0]  data2;
  logic [11:0] x2, y2;
  logic [15:0] fc2;

  int totalCnt = 0;
  int badCnt = 0;

  logic        vsA[256], hsA[256], vldA[256], fsA[256];
  logic [7:0]  dataA[256];
  logic [11:0] xA[256], yA[256];
  logic [15:0] fcA[256];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .DATA_W(8), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vld),
    .pre_img_data(data), .img_x(x), .img_y(y),
    .frame_start(fs), .frame_cnt(fc)
  );

  video_pattern_gen #(
    .H_SYNC(1), .H_BACK(1), .H_DISP(64), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(40), .V_FRONT(1),
    .DATA_W(8), .CNT_W(12)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2),
    .pre_img_vsync(vs2), .pre_img_hsync(hs2), .pre_img_valid(vld2),
    .pre_img_data(data2), .img_x(x2), .img_y(y2),
    .frame_start(fs2), .frame_cnt(fc2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] allOut();
    return {12'd0, vs, hs, vld, data, x, y, fs, fc};
  endfunction

  task automatic resetDut();
    en = 1'b0;
    mode = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Index c of the capture arrays holds outputs sampled at the c-th falling edge
  // after the rising edge that sampled en=1; they describe counter state c-1.
  task automatic applyStimulus(input int nCyc, input logic [1:0] startMode,
                               input int modeAt, input logic [1:0] newMode,
                               input int dropAt);
    @(negedge clk);
    en = 1'b1;
    mode = startMode;
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      vsA[c] = vs; hsA[c] = hs; vldA[c] = vld; fsA[c] = fs;
      dataA[c] = data; xA[c] = x; yA[c] = y; fcA[c] = fc;
      if (c == dropAt) en = 1'b0;
      if (c == modeAt) mode = newMode;
    end
  endtask

  initial begin
    int vCount, rises, fsGap, activity;
    int cnt6, frame1Valid, hits;
    bit done;

    // Test 1: reset and idle
    repeat (5) @(negedge clk);
    checkOutput("t1 vsync", vs, 0);
    checkOutput("t1 hsync", hs, 0);
    checkOutput("t1 valid", vld, 0);
    checkOutput("t1 data", data, 0);
    checkOutput("t1 x", x, 0);
    checkOutput("t1 y", y, 0);
    checkOutput("t1 fs", fs, 0);
    checkOutput("t1 fcnt", fc, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t1 idle", allOut(), 0);
    end

    // Test 2: mode 0 free-running
    applyStimulus(115, 2'd0, -1, 2'd0, -1);
    checkOutput("t2 fs c0", fsA[0], 0);
    checkOutput("t2 fs c1", fsA[1], 1);
    checkOutput("t2 hs c1", hsA[1], 1);
    checkOutput("t2 vs c1", vsA[1], 1);
    checkOutput("t2 vld c1", vldA[1], 0);
    checkOutput("t2 vs c16", vsA[16], 0);
    checkOutput("t2 hs line2", hsA[31], 1);
    checkOutput("t2 vld pre", vldA[35], 0);
    checkOutput("t2 vld first", vldA[36], 1);
    checkOutput("t2 data first", dataA[36], 0);
    checkOutput("t2 data last", dataA[43], 7);
    checkOutput("t2 x last", xA[43], 7);
    checkOutput("t2 y last", yA[43], 0);
    checkOutput("t2 vld post", vldA[44], 0);
    checkOutput("t2 data post", dataA[44], 0);
    checkOutput("t2 x post", xA[44], 0);
    checkOutput("t2 y row3", yA[81], 3);
    checkOutput("t2 data row3", dataA[81], 0);
    vCount = 0; rises = 0; fsGap = 0;
    for (int c = 1; c <= 105; c++) begin
      if (vldA[c]) vCount++;
      if (vldA[c] && !vldA[c-1]) rises++;
      if (c >= 2 && fsA[c]) fsGap++;
    end
    checkOutput("t2 valid count", vCount, 32);
    checkOutput("t2 valid lines", rises, 4);
    checkOutput("t2 fs gap", fsGap, 0);
    checkOutput("t2 fs c106", fsA[106], 1);
    checkOutput("t2 fcnt c104", fcA[104], 0);
    checkOutput("t2 fcnt c105", fcA[105], 1);
    checkOutput("t2 data f2", dataA[106], 0);

    // Test 3: en dropped at v=3,h=6 of the first frame
    resetDut();
    applyStimulus(130, 2'd0, -1, 2'd0, 51);
    vCount = 0;
    for (int c = 1; c <= 105; c++) if (vldA[c]) vCount++;
    checkOutput("t3 valid count", vCount, 32);
    checkOutput("t3 last pixel", {vldA[88], dataA[88], yA[88]}, {1'b1, 8'd7, 12'd3});
    checkOutput("t3 fcnt end", fcA[105], 1);
    activity = 0;
    for (int c = 106; c < 130; c++)
      if ({vsA[c], hsA[c], vldA[c], dataA[c], xA[c], yA[c], fsA[c]} != '0) activity++;
    checkOutput("t3 idle activity", activity, 0);
    checkOutput("t3 fcnt hold", fcA[129], 1);

    // Test 4: mode change mid-frame applies from the next frame
    resetDut();
    applyStimulus(200, 2'd0, 50, 2'd1, -1);
    checkOutput("t4 f1 x-ramp", dataA[83], 2);
    checkOutput("t4 f2 y0", dataA[141], 0);
    checkOutput("t4 f2 y1", dataA[161], 1);
    checkOutput("t4 f2 y2", dataA[171], 2);
    checkOutput("t4 f2 y3", dataA[193], 3);

    // Test 5: asynchronous reset mid-line
    resetDut();
    applyStimulus(56, 2'd0, -1, 2'd0, -1);
    checkOutput("t5 pre-reset vld", {vldA[55], dataA[55]}, {1'b1, 8'd4});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 async clear", allOut(), 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(107, 2'd0, -1, 2'd0, -1);
    checkOutput("t5 restart fs", fsA[1], 1);
    checkOutput("t5 restart fcnt", fcA[1], 0);
    checkOutput("t5 restart pixel", {vldA[36], dataA[36]}, {1'b1, 8'd0});
    checkOutput("t5 fcnt after", fcA[105], 1);
    en = 1'b0;

    // Test 6: checker pattern on the wide raster, two frames
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    en2 = 1'b1;
    mode2 = 2'd2;
    cnt6 = 0; frame1Valid = -1; hits = 0; done = 0;
    for (int c = 0; c < 6500 && !done; c++) begin
      @(negedge clk);
      if (vld2) begin
        cnt6++;
        if (x2 == 12'd32 && y2 == 12'd0) begin hits++; checkOutput("t6 px(32,0)", data2, 8'hFF); end
        if (x2 == 12'd0 && y2 == 12'd0) begin hits++; checkOutput("t6 px(0,0)", data2, 8'h00); end
        if (x2 == 12'd32 && y2 == 12'd32) begin hits++; checkOutput("t6 px(32,32)", data2, 8'h00); end
      end
      if (fc2 == 16'd1 && frame1Valid < 0) frame1Valid = cnt6;
      if (fc2 == 16'd2) done = 1;
    end
    checkOutput("t6 fcnt", fc2, 2);
    checkOutput("t6 frame1 valid", frame1Valid, 2560);
    checkOutput("t6 total valid", cnt6, 5120);
    checkOutput("t6 pixel hits", hits, 6);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
